// File: rtl/ir_cmd_dispatcher_if.sv
// ir_cmd_dispatcher_if
// Groups the IR-receiver side (frame_valid, frame, mode) and the uart_tx
// valid/ready side (tx_valid, tx_byte, tx_ready) of the command dispatcher.
//   master : environment side; drives frames, mode switches and tx_ready.
//   slave  : dispatcher side; consumes frames, offers event bytes.
interface ir_cmd_dispatcher_if;
  logic        frame_valid;
  logic [31:0] frame;
  logic [1:0]  mode;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;

  modport master (
    output frame_valid, frame, mode, tx_ready,
    input  tx_valid, tx_byte
  );

  modport slave (
    input  frame_valid, frame, mode, tx_ready,
    output tx_valid, tx_byte
  );
endinterface

// File: rtl/ir_cmd_dispatcher.sv
// ir_cmd_dispatcher
// Converts decoded NEC IR frames into a held one-hot motor command and a
// stream of press/release event bytes for a UART transmitter.
// Ports:
//   clk, rst_n   : 50 MHz clock, asynchronous active-low reset
//   bus (slave)  : frame_valid/frame/mode in, tx_valid/tx_byte out, tx_ready in
//   cmd_onehot   : active command, one-hot (0 when idle)
//   cmd_code     : binary index of the active command (0 when idle)
//   cmd_active   : high while a command is held
//   err_count    : saturating count of rejected frames
//   overflow     : sticky, an event was dropped because the FIFO was full
module ir_cmd_dispatcher #(
  parameter int                  N_CMDS      = 8,
  parameter logic [N_CMDS*8-1:0] KEY_MAP     = {8'h08, 8'h07, 8'h06, 8'h05,
                                                8'h04, 8'h01, 8'h02, 8'h00},
  parameter int                  HOLD_CYCLES = 6_000_000,
  parameter bit                  CHECK_INV   = 1'b1,
  parameter bit                  ADDR_FILTER = 1'b0,
  parameter logic [15:0]         ADDR_VALUE  = 16'h0000,
  parameter int                  FIFO_DEPTH  = 4,
  localparam int                 CODE_W      = $clog2(N_CMDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ir_cmd_dispatcher_if.slave      bus,
  output logic [N_CMDS-1:0]       cmd_onehot,
  output logic [CODE_W-1:0]       cmd_code,
  output logic                    cmd_active,
  output logic [7:0]              err_count,
  output logic                    overflow
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                fv_r;         // frame_valid history for edge detect
  logic                pend_r;       // captured frame awaiting evaluation
  logic [31:0]         frame_r;
  logic                sw_pend_r;    // second (press) push of a key switch
  logic [N_CMDS-1:0]   cmd_onehot_r;
  logic [CODE_W-1:0]   cmd_code_r;
  logic                cmd_active_r;
  logic [7:0]          err_count_r;
  logic                overflow_r;

  logic [7:0]          mem_r [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_r;
  logic [AW:0]         rd_ptr_r;

  logic                hit_s;
  logic [CODE_W-1:0]   slot_s;
  logic                accept_s;
  logic                reject_s;
  logic                push_s;
  logic                push_press_s;
  logic [CODE_W-1:0]   push_code_s;
  logic [7:0]          push_byte_s;
  logic                empty_s;
  logic                full_s;
  logic                pop_s;
  logic                wr_ok_s;

  // Key lookup; scanning downward lets the lowest matching slot win.
  always_comb begin
    hit_s  = 1'b0;
    slot_s = '0;
    for (int i = N_CMDS - 1; i >= 0; i--) begin
      if (KEY_MAP[8*i +: 8] == frame_r[23:16]) begin
        hit_s  = 1'b1;
        slot_s = CODE_W'(i);
      end else begin
        hit_s  = hit_s;
      end
    end
  end

  // Frame integrity, address and key checks on the captured frame.
  always_comb begin
    accept_s = pend_r && hit_s
               && (!CHECK_INV   || (frame_r[31:24] == ~frame_r[23:16]))
               && (!ADDR_FILTER || (frame_r[15:0]  == ADDR_VALUE));
    reject_s = pend_r && !accept_s;
  end

  // Event push selection; at most one push per cycle. The press half of a
  // switch always lands on the cycle after its release.
  always_comb begin
    push_s       = 1'b0;
    push_press_s = 1'b0;
    push_code_s  = '0;
    if (sw_pend_r) begin
      push_s       = 1'b1;
      push_press_s = 1'b1;
      push_code_s  = cmd_code_r;
    end else if (accept_s) begin
      if (state_r == IDLE) begin
        push_s       = 1'b1;
        push_press_s = 1'b1;
        push_code_s  = slot_s;
      end else if (slot_s != cmd_code_r) begin
        push_s       = 1'b1;
        push_code_s  = cmd_code_r;
      end else begin
        push_s       = 1'b0;
      end
    end else if ((state_r == HOLD) && (cnt_r == '0)) begin
      push_s      = 1'b1;
      push_code_s = cmd_code_r;
    end else begin
      push_s      = 1'b0;
    end
    push_byte_s = {bus.mode, push_press_s, 5'(push_code_s)};
  end

  // FIFO status and handshake.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s   = !empty_s && bus.tx_ready;
    wr_ok_s = push_s && (!full_s || pop_s);
  end

  // Edge detect, frame capture, command FSM, hold counter and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      fv_r         <= 1'b0;
      pend_r       <= 1'b0;
      frame_r      <= 32'h0000_0000;
      sw_pend_r    <= 1'b0;
      cmd_onehot_r <= '0;
      cmd_code_r   <= '0;
      cmd_active_r <= 1'b0;
      err_count_r  <= 8'h00;
    end else begin
      fv_r      <= bus.frame_valid;
      pend_r    <= bus.frame_valid && !fv_r;
      sw_pend_r <= 1'b0;
      if (bus.frame_valid && !fv_r) begin
        frame_r <= bus.frame;
      end else begin
        frame_r <= frame_r;
      end
      if (reject_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'h01;
      end else begin
        err_count_r <= err_count_r;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r      <= HOLD;
            cnt_r        <= CNT_LOAD;
            cmd_onehot_r <= N_CMDS'(1) << slot_s;
            cmd_code_r   <= slot_s;
            cmd_active_r <= 1'b1;
          end else begin
            cnt_r        <= '0;
          end
        end
        HOLD: begin
          // An accepted frame takes priority over a simultaneous timeout.
          if (accept_s) begin
            cnt_r <= CNT_LOAD;
            if (slot_s != cmd_code_r) begin
              cmd_onehot_r <= N_CMDS'(1) << slot_s;
              cmd_code_r   <= slot_s;
              sw_pend_r    <= 1'b1;
            end else begin
              cmd_code_r   <= cmd_code_r;
            end
          end else if (cnt_r == '0) begin
            state_r      <= IDLE;
            cmd_onehot_r <= '0;
            cmd_code_r   <= '0;
            cmd_active_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= '0;
          cmd_onehot_r <= '0;
          cmd_code_r   <= '0;
          cmd_active_r <= 1'b0;
        end
      endcase
    end
  end

  // Event FIFO storage, pointers and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_byte_s;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (push_s && !wr_ok_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign bus.tx_valid = !empty_s;
  assign bus.tx_byte  = empty_s ? 8'h00 : mem_r[rd_ptr_r[AW-1:0]];
  assign cmd_onehot   = cmd_onehot_r;
  assign cmd_code     = cmd_code_r;
  assign cmd_active   = cmd_active_r;
  assign err_count    = err_count_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_ir_cmd_dispatcher.sv
// Self-checking bench for ir_cmd_dispatcher with HOLD_CYCLES=100.
// Expected event bytes are queued when stimulus is driven and compared
// whenever the DUT hands a byte over (tx_valid && tx_ready).
module tb_ir_cmd_dispatcher;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_onehot;
  logic [2:0] cmd_code;
  logic       cmd_active;
  logic [7:0] err_count;
  logic       overflow;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ir_cmd_dispatcher_if bus();

  ir_cmd_dispatcher #(.HOLD_CYCLES(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .cmd_onehot (cmd_onehot),
    .cmd_code   (cmd_code),
    .cmd_active (cmd_active),
    .err_count  (err_count),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ev(input logic [1:0] m, input logic p, input logic [4:0] c);
    return {m, p, c};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f);
    bus.frame       = f;
    bus.frame_valid = 1'b1;
    cyc(1);
    bus.frame_valid = 1'b0;
  endtask

  // Scoreboard: every handed-over byte must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) chk("tx_extra", 32'(bus.tx_byte), 32'h100);
      else chk("tx_byte", 32'(bus.tx_byte), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    bus.frame_valid = 1'b0;
    bus.frame       = 32'h0000_0000;
    bus.mode        = 2'b10;
    bus.tx_ready    = 1'b1;
    cyc(3);
    chk("rst_onehot", 32'(cmd_onehot), 32'h0);
    chk("rst_code", 32'(cmd_code), 32'h0);
    chk("rst_active", 32'(cmd_active), 32'h0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_tx_byte", 32'(bus.tx_byte), 32'h0);
    chk("rst_err", 32'(err_count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // First press
    exp_q.push_back(ev(2'b10, 1'b1, 5'd1));
    send(32'hFD02_0000);
    cyc(1);
    chk("t1_onehot", 32'(cmd_onehot), 32'h02);
    chk("t1_code", 32'(cmd_code), 32'h1);
    chk("t1_active", 32'(cmd_active), 32'h1);
    chk("t1_valid", 32'(bus.tx_valid), 32'h1);
    cyc(1);
    chk("t1_valid_once", 32'(bus.tx_valid), 32'h0);

    // Repeats keep the command held, then timeout releases it
    for (int i = 0; i < 5; i++) begin
      cyc(48);
      chk("t2_hold", 32'(cmd_onehot), 32'h02);
      send(32'hFD02_0000);
    end
    cyc(90);
    chk("t2_still", 32'(cmd_active), 32'h1);
    exp_q.push_back(ev(2'b10, 1'b0, 5'd1));
    cyc(12);
    chk("t2_clr_onehot", 32'(cmd_onehot), 32'h0);
    chk("t2_clr_active", 32'(cmd_active), 32'h0);
    cyc(3);
    chk("t2_sb", 32'(exp_q.size()), 32'h0);

    // Key switch while held
    bus.mode = 2'b01;
    exp_q.push_back(ev(2'b01, 1'b1, 5'd1));
    send(32'hFD02_0000);
    cyc(5);
    exp_q.push_back(ev(2'b01, 1'b0, 5'd1));
    exp_q.push_back(ev(2'b01, 1'b1, 5'd5));
    send(32'hF906_0000);
    cyc(1);
    chk("t3_onehot", 32'(cmd_onehot), 32'h20);
    chk("t3_code", 32'(cmd_code), 32'h5);
    cyc(3);
    chk("t3_sb", 32'(exp_q.size()), 32'h0);
    exp_q.push_back(ev(2'b01, 1'b0, 5'd5));
    cyc(110);
    chk("t3_idle", 32'(cmd_active), 32'h0);
    chk("t3_sb2", 32'(exp_q.size()), 32'h0);

    // Rejected frames
    bus.mode = 2'b10;
    send(32'h0002_0000);
    cyc(1);
    send(32'hF00F_0000);
    cyc(2);
    chk("t4_err", 32'(err_count), 32'h2);
    chk("t4_active", 32'(cmd_active), 32'h0);
    chk("t4_onehot", 32'(cmd_onehot), 32'h0);
    chk("t4_tx_valid", 32'(bus.tx_valid), 32'h0);
    for (int i = 0; i < 300; i++) begin
      send(32'h0002_0000);
      cyc(1);
    end
    cyc(2);
    chk("t4_err_sat", 32'(err_count), 32'hFF);

    // Overflow with a stalled consumer
    bus.tx_ready = 1'b0;
    exp_q.push_back(ev(2'b10, 1'b1, 5'd1));
    send(32'hFD02_0000);
    cyc(3);
    chk("t5_head", 32'(bus.tx_byte), 32'hA1);
    exp_q.push_back(ev(2'b10, 1'b0, 5'd1));
    exp_q.push_back(ev(2'b10, 1'b1, 5'd5));
    send(32'hF906_0000);
    cyc(3);
    exp_q.push_back(ev(2'b10, 1'b0, 5'd5));
    send(32'hFE01_0000);
    cyc(113);
    chk("t5_ovf", 32'(overflow), 32'h1);
    chk("t5_valid", 32'(bus.tx_valid), 32'h1);
    chk("t5_stable", 32'(bus.tx_byte), 32'hA1);
    chk("t5_idle", 32'(cmd_active), 32'h0);
    bus.tx_ready = 1'b1;
    cyc(8);
    chk("t5_drained", 32'(bus.tx_valid), 32'h0);
    chk("t5_sb", 32'(exp_q.size()), 32'h0);

    // Level-held frame_valid is one acceptance
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_ovf_clr", 32'(overflow), 32'h0);
    bus.frame       = 32'h0002_0000;
    bus.frame_valid = 1'b1;
    cyc(20);
    bus.frame_valid = 1'b0;
    cyc(2);
    chk("t6_err_once", 32'(err_count), 32'h1);
    exp_q.push_back(ev(2'b10, 1'b1, 5'd1));
    bus.frame       = 32'hFD02_0000;
    bus.frame_valid = 1'b1;
    cyc(20);
    bus.frame_valid = 1'b0;
    cyc(3);
    chk("t6_active", 32'(cmd_active), 32'h1);
    chk("t6_sb", 32'(exp_q.size()), 32'h0);

    // Reset while holding with queued events
    bus.tx_ready = 1'b0;
    send(32'hF906_0000);
    cyc(3);
    chk("t7_pre_valid", 32'(bus.tx_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_onehot", 32'(cmd_onehot), 32'h0);
    chk("t7_code", 32'(cmd_code), 32'h0);
    chk("t7_active", 32'(cmd_active), 32'h0);
    chk("t7_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("t7_tx_byte", 32'(bus.tx_byte), 32'h0);
    chk("t7_err", 32'(err_count), 32'h0);
    cyc(2);
    bus.tx_ready = 1'b1;
    rst_n = 1'b1;
    cyc(3);
    chk("t7_after", 32'(bus.tx_valid), 32'h0);
    chk("end_sb", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ir_cmd_dispatcher.md
Name: ir_cmd_dispatcher

Overview:
- Turns decoded NEC IR remote frames into a held, debounced one-hot motor command plus a byte stream of press/release events for the UART transmitter.
- Sits between the IR receiver output (32-bit frame, data-ready) and both the motor controller command input and the uart_tx valid/ready port.
- Generalises the top-level key-case logic:
  - parametrised key map and command count;
  - frame integrity and address checks;
  - repeat-hold timeout;
  - event FIFO with overflow flag.

Parameters:
- N_CMDS, 8, number of command slots (2..32); CODE_W = $clog2(N_CMDS).
- KEY_MAP, {8'h08,8'h07,8'h06,8'h05,8'h04,8'h01,8'h02,8'h00}, packed N_CMDS*8 key bytes; slot i = KEY_MAP[8i+7:8i].
- HOLD_CYCLES, 6_000_000, cycles a command stays asserted after its last frame (120 ms at 50 MHz, exceeds the NEC 108 ms repeat period).
- CHECK_INV, 1, when 1, reject frames whose frame[31:24] != ~frame[23:16].
- ADDR_FILTER, 0, when 1, reject frames whose frame[15:0] != ADDR_VALUE.
- ADDR_VALUE, 16'h0000, accepted remote address.
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- frame_valid  in  1  IR receiver data-ready; level or pulse accepted.
- frame  in  32  decoded frame: [15:0] address, [23:16] key, [31:24] inverted key.
- mode  in  2  operator mode bits (switches), copied into event bytes.
- cmd_onehot  out  N_CMDS  active command, one-hot, or all zero when idle.
- cmd_code  out  CODE_W  binary index of the active command, 0 when idle.
- cmd_active  out  1  high while a command is held.
- tx_valid  out  1  event byte available.
- tx_byte  out  8  event byte at FIFO head.
- tx_ready  in  1  uart_tx ready.
- err_count  out  8  rejected-frame counter, saturates at 255.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync release):
  - cmd_onehot, cmd_code, cmd_active, err_count, overflow = 0.
  - FIFO empty, so tx_valid=0 and tx_byte=0.
  - State IDLE, hold counter 0, frame_valid history register 0.
- Frame acceptance:
  - A frame is accepted on a rising edge of frame_valid: sampled 1 at edge N after a sample of 0.
  - frame is captured at edge N. Results are visible after edge N+1 (latency 2 edges).
- Rejection: the frame is rejected if the CHECK_INV test fails, the ADDR_FILTER test fails, or no KEY_MAP slot equals the key.
  - Reject action: err_count +1 (saturating), no other state change.
  - If a key appears in several slots, the lowest slot index wins.
- State IDLE, on an accepted frame for slot k:
  - Go to HOLD.
  - cmd_onehot = 1<<k, cmd_code = k, cmd_active = 1.
  - Counter = HOLD_CYCLES-1.
  - Push press event.
- State HOLD, same slot k accepted: reload the counter, no push (repeat).
- State HOLD, different slot j accepted:
  - Push release event for k, then press event for j, in that order.
  - Switch outputs to j and reload the counter.
- State HOLD, no frame: decrement the counter. When it is 0:
  - Go to IDLE and clear the outputs.
  - Push release event for k.
- Timeout and accepted frame in the same cycle: the frame wins (treated as a HOLD-state frame).
- Event byte = {mode[1:0], press, code zero-extended to 5 bits}; press = 1 for a press, 0 for a release. mode is sampled when the event is pushed.
- FIFO:
  - tx_valid = !empty; tx_byte = head entry (0 when empty).
  - Pop when tx_valid && tx_ready.
  - Push is permitted when not full, or when a pop occurs in the same cycle.
  - A pushed event with no slot is dropped and overflow is set.
  - The two-event switch case is pushed on consecutive cycles. The second push is subject to the same full check.
  - tx_byte is held stable while tx_valid=1 and tx_ready=0.
- Reset mid-operation: everything returns to reset values immediately; pending events are discarded.

Test Plan (HOLD_CYCLES=100 on the bench):
- Reset, then frame 32'hFD02_0000 pulse with tx_ready=1, mode=2'b10 -> two edges later cmd_onehot=8'h02, cmd_code=1, cmd_active=1; tx_byte=8'hA1, valid for one cycle.
- Same frame repeated every 50 cycles, 5 times, then stopped -> cmd_onehot stays 8'h02 throughout; about 100 cycles after the last frame it clears; exactly one release byte 8'h81 is sent; no extra presses.
- Frame 32'hFD02_0000, then 32'hF906_0000 while held -> events 8'h81 then 8'hA5 in order; cmd_onehot=8'h20, cmd_code=5.
- Bad inverse 32'h0002_0000, then unmapped key 32'hF00F_0000 -> err_count=2; outputs and FIFO unchanged. 300 bad frames -> err_count holds at 255.
- tx_ready=0, generate 3 press/release pairs (6 events) -> first 4 queued, overflow=1, tx_byte stable. Raise tx_ready -> 4 bytes drain in order, then tx_valid=0.
- frame_valid held high 20 cycles -> only one acceptance. Assert rst_n=0 while in HOLD with FIFO non-empty -> all outputs 0 immediately, tx_valid=0.
